// File: rtl/sdrd_pkg.sv
// Shared definitions for the serial key sequencer.
//   state_t      : 2-bit sequencer state (LOCKED, U1, U2, STREAM)
//   WIN_BA13/12  : required values of ba[13]/ba[12] for the serial window
package sdrd_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED = 2'd0,
        ST_U1     = 2'd1,
        ST_U2     = 2'd2,
        ST_STREAM = 2'd3
    } state_t;

    localparam logic WIN_BA13 = 1'b0;
    localparam logic WIN_BA12 = 1'b1;

endpackage

// File: rtl/sdrd_window_dec.sv
// Window and access-qualify decode for the serial key sequencer.
// Ports:
//   sser_n   in  serial-device select, active low
//   ba_13    in  bus address bit 13
//   ba_12    in  bus address bit 12
//   br_w     in  bus direction, 1 = read
//   bus_stb  in  single-cycle access strobe
//   hit      out window hit (select asserted and address in window)
//   rd_hit   out hit with read direction, regardless of strobe
//   rd_qual  out strobed read inside the window
//   wr_qual  out strobed write inside the window
module sdrd_window_dec
    import sdrd_pkg::*;
(
    input  logic sser_n,
    input  logic ba_13,
    input  logic ba_12,
    input  logic br_w,
    input  logic bus_stb,
    output logic hit,
    output logic rd_hit,
    output logic rd_qual,
    output logic wr_qual
);

    assign hit     = ~sser_n & (ba_13 == WIN_BA13) & (ba_12 == WIN_BA12);
    assign rd_hit  = hit & br_w;
    assign rd_qual = bus_stb & hit & br_w;
    assign wr_qual = bus_stb & hit & ~br_w;

endmodule

// File: rtl/sdrd_sequencer.sv
// Serial key sequencer. Three reads at the unlock offsets (ba[7:4]) open a
// stream; each further read in the window presents the next KEY bit on sdrd
// (LSB first). The sixteenth streamed read relocks. Any write in the window
// aborts back to LOCKED.
// Bus handshake: bus_stb is a one-cycle strobe with no ready/back-pressure;
// an access is taken on the rising edge that ends the strobe cycle, and the
// data bit for a read is valid combinationally during that same cycle.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   sser_n      serial-device select, active low
//   ba[13:0]    bus address (ba[13], ba[12], ba[7:4] decoded)
//   br_w        1 = read, 0 = write
//   bus_stb     access strobe
//   sdrd        key data bit (0 when not driven)
//   sdrd_oe     drive enable for sdrd
//   state_o     current state (debug)
//   bit_cnt_o   current key bit index (debug)
module sdrd_sequencer
    import sdrd_pkg::*;
#(
    parameter logic [15:0] KEY     = 16'hA5C3,
    parameter logic [3:0]  UNLOCK0 = 4'h2,
    parameter logic [3:0]  UNLOCK1 = 4'hA,
    parameter logic [3:0]  UNLOCK2 = 4'hB
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sser_n,
    input  logic [13:0] ba,
    input  logic        br_w,
    input  logic        bus_stb,
    output logic        sdrd,
    output logic        sdrd_oe,
    output logic [1:0]  state_o,
    output logic [3:0]  bit_cnt_o
);

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       hit, rd_hit, rd_qual, wr_qual;
    logic [3:0] offset;
    logic       unused_ba;

    sdrd_window_dec u_dec (
        .sser_n  (sser_n),
        .ba_13   (ba[13]),
        .ba_12   (ba[12]),
        .br_w    (br_w),
        .bus_stb (bus_stb),
        .hit     (hit),
        .rd_hit  (rd_hit),
        .rd_qual (rd_qual),
        .wr_qual (wr_qual)
    );

    assign offset    = ba[7:4];
    assign unused_ba = ^{ba[11:8], ba[3:0]};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        if (wr_qual) begin
            // Abort outranks every read transition.
            state_d   = ST_LOCKED;
            bit_cnt_d = 4'd0;
        end else if (rd_qual) begin
            case (state_q)
                ST_LOCKED: begin
                    if (offset == UNLOCK0) state_d = ST_U1;
                end
                ST_U1: begin
                    if (offset == UNLOCK1)      state_d = ST_U2;
                    else if (offset != UNLOCK0) state_d = ST_LOCKED;
                end
                ST_U2: begin
                    if (offset == UNLOCK2) begin
                        state_d   = ST_STREAM;
                        bit_cnt_d = 4'd0;
                    end else if (offset == UNLOCK0) begin
                        state_d = ST_U1;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
                ST_STREAM: begin
                    // Offset is ignored while streaming.
                    if (bit_cnt_q == 4'hF) begin
                        state_d   = ST_LOCKED;
                        bit_cnt_d = 4'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d   = ST_LOCKED;
                    bit_cnt_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_LOCKED;
            bit_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // The bit shown during a streamed read is the pre-increment index.
    assign sdrd_oe   = (state_q == ST_STREAM) & rd_hit;
    assign sdrd      = sdrd_oe & KEY[bit_cnt_q];
    assign state_o   = state_q;
    assign bit_cnt_o = bit_cnt_q;

endmodule

// File: tb/tb_sdrd_sequencer.sv
module tb_sdrd_sequencer;

  localparam logic [15:0] KEY = 16'hA5C3;
  localparam logic [3:0]  U0  = 4'h2;
  localparam logic [3:0]  U1  = 4'hA;
  localparam logic [3:0]  U2  = 4'hB;

  logic        clk;
  logic        rst_n;
  logic        sser_n;
  logic [13:0] ba;
  logic        br_w;
  logic        bus_stb;
  logic        sdrd;
  logic        sdrd_oe;
  logic [1:0]  state_o;
  logic [3:0]  bit_cnt_o;

  sdrd_sequencer #(
    .KEY     (KEY),
    .UNLOCK0 (U0),
    .UNLOCK1 (U1),
    .UNLOCK2 (U2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sser_n    (sser_n),
    .ba        (ba),
    .br_w      (br_w),
    .bus_stb   (bus_stb),
    .sdrd      (sdrd),
    .sdrd_oe   (sdrd_oe),
    .state_o   (state_o),
    .bit_cnt_o (bit_cnt_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];

  // reference model: unlock progress (0..3, 3 = streaming) and key index
  int         m_prog = 0;
  int         m_idx  = 0;
  logic [15:0] key_v = KEY;
  logic [3:0]  unlock_seq[3] = '{U0, U1, U2};

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got state=%0d bit=%0d oe=%0d sdrd=%0d, expected state=%0d bit=%0d oe=%0d sdrd=%0d",
                  name, $time, act[7:6], act[5:2], act[1], act[0], exp[7:6], exp[5:2], exp[1], exp[0]);
  endtask

  function automatic logic [7:0] model_out(input logic s_n, input logic [13:0] a, input logic rw);
    logic hit, oe;
    hit = !s_n && !a[13] && a[12];
    oe  = (m_prog == 3) && hit && rw;
    return {2'(m_prog), 4'(m_idx), oe, oe & key_v[m_idx]};
  endfunction

  task automatic model_step(input logic stb, input logic s_n, input logic [13:0] a, input logic rw);
    logic hit;
    hit = !s_n && !a[13] && a[12];
    if (stb && hit) begin
      if (!rw) begin
        m_prog = 0;
        m_idx  = 0;
      end else if (m_prog < 3) begin
        if (a[7:4] == unlock_seq[m_prog]) m_prog++;
        else if (a[7:4] == U0)            m_prog = 1;
        else                              m_prog = 0;
        m_idx = 0;
      end else begin
        m_idx++;
        if (m_idx == 16) begin
          m_prog = 0;
          m_idx  = 0;
        end
      end
    end
  endtask

  // driver: one bus cycle, expected output for that cycle goes to the scoreboard
  task automatic drive(input logic stb, input logic s_n, input logic b13, input logic b12,
                       input logic [3:0] off, input logic rw);
    logic [13:0] a;
    @(posedge clk);
    #1;
    a = {b13, b12, 4'($urandom), off, 4'($urandom)};
    bus_stb = stb;
    sser_n  = s_n;
    ba      = a;
    br_w    = rw;
    exp_q.push_back(model_out(s_n, a, rw));
    model_step(stb, s_n, a, rw);
  endtask

  task automatic rd(input logic [3:0] off);
    drive(1'b1, 1'b0, 1'b0, 1'b1, off, 1'b1);
  endtask

  task automatic wr();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'($urandom), 1'b0);
  endtask

  task automatic idle_hit();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'($urandom), 1'b1);
  endtask

  task automatic unlock();
    rd(U0); rd(U1); rd(U2);
  endtask

  // monitor: compare DUT outputs against the queued expectation each cycle
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check("cycle", {state_o, bit_cnt_o, sdrd_oe, sdrd}, e);
    end
  end

  initial begin
    rst_n   = 1'b0;
    bus_stb = 1'b0;
    sser_n  = 1'b0;
    ba      = 14'h1000;
    br_w    = 1'b1;
    #2;
    check("reset", {state_o, bit_cnt_o, sdrd_oe, sdrd}, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // basic unlock, first key bit visible in the window
    unlock();
    idle_hit();

    // full 16-bit stream, then relock
    for (int i = 0; i < 16; i++) rd(4'($urandom));
    idle_hit();

    // repeated UNLOCK0 re-enters U1
    rd(U0); rd(U1); rd(U0); rd(U1); rd(U2);
    idle_hit();
    wr();
    rd(U0); rd(4'h5);
    idle_hit();

    // write abort mid-stream at bit 7
    unlock();
    for (int i = 0; i < 7; i++) rd(4'($urandom));
    wr();
    idle_hit();

    // strobes outside the window at bit 4, then async reset
    unlock();
    for (int i = 0; i < 4; i++) rd(4'($urandom));
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'($urandom), 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'($urandom), 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'($urandom), 1'b0);
    idle_hit();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {state_o, bit_cnt_o, sdrd_oe, sdrd}, 8'h00);
    m_prog = 0;
    m_idx  = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle_hit();
    rd(U0);
    idle_hit();

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      int r;
      logic [3:0] off;
      r = $urandom_range(0, 5);
      off = (r == 0) ? U0 : (r == 1) ? U1 : (r == 2) ? U2 : 4'($urandom);
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) != 0,
            off,
            $urandom_range(0, 15) != 0);
    end
    @(posedge clk);
    #1 bus_stb = 1'b0;

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
